// File: rtl/rs_pkg.sv
// GF(16) field constants, generator coefficients, FSM state type and the
// shared GF(16) multiply used by the RS(15,9) encoder and its bench models.
package rs_pkg;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int K     = 9;
  localparam int NPAR  = N - K;

  // x^4 + x + 1
  localparam logic [SYM_W:0] PRIM_POLY = 5'b10011;

  // alpha^0 .. alpha^14 with alpha = x
  localparam logic [SYM_W-1:0] ALPHA_POW [0:N-1] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  // g(x) = prod_{i=1..6} (x + alpha^i), monic in x^6
  localparam logic [SYM_W-1:0] G0 = 4'hC;
  localparam logic [SYM_W-1:0] G1 = 4'hA;
  localparam logic [SYM_W-1:0] G2 = 4'hC;
  localparam logic [SYM_W-1:0] G3 = 4'h3;
  localparam logic [SYM_W-1:0] G4 = 4'h9;
  localparam logic [SYM_W-1:0] G5 = 4'h7;
  localparam logic [SYM_W-1:0] GEN_COEF [0:NPAR-1] = '{G0, G1, G2, G3, G4, G5};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shift-and-add polynomial multiply, reducing by the primitive polynomial
  // each time the running multiplicand overflows degree 3.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ aa;
      if (aa[SYM_W-1]) aa = {aa[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0];
      else             aa = {aa[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf16_mult.sv
// Combinational 4x4 GF(16) multiplier (one per LFSR tap).
module gf16_mult
  import rs_pkg::*;
(
  input  logic [SYM_W-1:0] i_a,
  input  logic [SYM_W-1:0] i_b,
  output logic [SYM_W-1:0] o_p
);

  assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/rs_encoder_seq.sv
// Sequential systematic RS(15,9) encoder over GF(16). The message is latched
// on start, fed highest symbol first through a 6-tap LFSR (one symbol per
// clock), and the packed codeword {message, parity} is held until accepted.
module rs_encoder_seq #(
  parameter int SYM_W = 4,
  parameter int N     = 15,
  parameter int K     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [K*SYM_W-1:0]   messageIn,
  input  logic                 encodeMessage,
  output logic                 encoderBusy,
  output logic [N*SYM_W-1:0]   codeWordOut,
  output logic                 codeWordValid,
  input  logic                 codeWordAccept
);

  localparam int NPAR = N - K;

  rs_pkg::state_t               r_state;
  rs_pkg::state_t               w_state_nxt;
  logic [K*SYM_W-1:0]           r_msg;
  logic [NPAR-1:0][SYM_W-1:0]   r_par;
  logic [NPAR-1:0][SYM_W-1:0]   w_par_nxt;
  logic [NPAR-1:0][SYM_W-1:0]   w_prod;
  logic [3:0]                   r_cnt;
  logic [N*SYM_W-1:0]           r_cw;
  logic                         r_valid;
  logic [SYM_W-1:0]             w_sym;
  logic [SYM_W-1:0]             w_fb;
  logic                         w_start;
  logic                         w_shift;
  logic                         w_last;
  logic                         w_accept;

  assign w_start  = (r_state == rs_pkg::ST_IDLE)  && encodeMessage;
  assign w_shift  = (r_state == rs_pkg::ST_SHIFT);
  assign w_last   = w_shift && (r_cnt == 4'd0);
  assign w_accept = (r_state == rs_pkg::ST_DONE)  && codeWordAccept;

  // Current message symbol selected by the down-counter, plus LFSR feedback.
  assign w_sym = r_msg[int'(r_cnt)*SYM_W +: SYM_W];
  assign w_fb  = w_sym ^ r_par[NPAR-1];

  // One constant multiplier per generator tap.
  for (genvar k = 0; k < NPAR; k++) begin : g_tap
    gf16_mult u_mul (
      .i_a (w_fb),
      .i_b (rs_pkg::GEN_COEF[k]),
      .o_p (w_prod[k])
    );
  end

  // Next parity register contents for one LFSR step.
  always_comb begin
    w_par_nxt    = '0;
    w_par_nxt[0] = w_prod[0];
    for (int k = 1; k < NPAR; k++) begin
      w_par_nxt[k] = r_par[k-1] ^ w_prod[k];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= rs_pkg::ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: start only from IDLE, finish after the counter-0 step,
  // release on accept (a same-cycle start request is not seen in DONE).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      rs_pkg::ST_IDLE:  if (encodeMessage)  w_state_nxt = rs_pkg::ST_SHIFT;
      rs_pkg::ST_SHIFT: if (r_cnt == 4'd0)  w_state_nxt = rs_pkg::ST_DONE;
      rs_pkg::ST_DONE:  if (codeWordAccept) w_state_nxt = rs_pkg::ST_IDLE;
      default:                              w_state_nxt = rs_pkg::ST_IDLE;
    endcase
  end

  // Message latch, LFSR parity registers and symbol counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg <= '0;
      r_par <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_msg <= messageIn;
      r_par <= '0;
      r_cnt <= 4'(K - 1);
    end else if (w_shift) begin
      r_par <= w_par_nxt;
      if (!w_last) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Codeword output register and valid flag; the word persists after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw    <= '0;
      r_valid <= 1'b0;
    end else if (w_last) begin
      r_cw    <= {r_msg, w_par_nxt};
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign encoderBusy   = (r_state != rs_pkg::ST_IDLE);
  assign codeWordOut   = r_cw;
  assign codeWordValid = r_valid;

endmodule

// File: tb/tb_rs_encoder_seq.sv
// Bench for rs_encoder_seq: a transaction-level model (polynomial division
// reference, syndrome evaluation) checked every cycle, plus directed tests.
module tb_rs_encoder_seq;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] messageIn;
  logic        encodeMessage;
  logic        codeWordAccept;
  logic        encoderBusy;
  logic [59:0] codeWordOut;
  logic        codeWordValid;

  rs_encoder_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .messageIn      (messageIn),
    .encodeMessage  (encodeMessage),
    .encoderBusy    (encoderBusy),
    .codeWordOut    (codeWordOut),
    .codeWordValid  (codeWordValid),
    .codeWordAccept (codeWordAccept)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] apow  [0:14];
  logic [3:0] gpoly [0:6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Systematic codeword by long division of m(x)*x^6 by g(x).
  function automatic logic [59:0] ref_encode(input logic [35:0] msg);
    logic [3:0]  d [0:14];
    logic [3:0]  q;
    logic [59:0] cw;
    for (int i = 0; i < 15; i++) d[i] = 4'h0;
    for (int j = 0; j < 9; j++) d[j+6] = msg[4*j +: 4];
    for (int i = 14; i >= 6; i--) begin
      q = d[i];
      for (int k = 0; k <= 6; k++) d[i-6+k] = d[i-6+k] ^ gf_mul(q, gpoly[k]);
    end
    cw = '0;
    for (int j = 0; j < 9; j++) cw[4*(j+6) +: 4] = msg[4*j +: 4];
    for (int i = 0; i < 6; i++) cw[4*i +: 4] = d[i];
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [59:0] cw, input int j);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 15; i++) s = s ^ gf_mul(cw[4*i +: 4], apow[(i*j) % 15]);
    return s;
  endfunction

  // Transaction model: idle -> 9 steps -> holding result until accepted.
  logic        m_busy, m_valid;
  int          m_left;
  logic [35:0] m_msg;
  logic [59:0] m_cw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_msg   <= '0;
      m_cw    <= '0;
    end else if (!m_busy) begin
      if (encodeMessage) begin
        m_busy <= 1'b1;
        m_left <= 9;
        m_msg  <= messageIn;
      end
    end else if (!m_valid) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_cw    <= ref_encode(m_msg);
      end
    end else if (codeWordAccept) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  task automatic run_encode(input logic [35:0] msg, output logic [59:0] cw, output int lat);
    messageIn     = msg;
    encodeMessage = 1'b1;
    @(negedge clk);
    encodeMessage = 1'b0;
    lat = 0;
    while (!codeWordValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!codeWordValid) begin
      check("valid_timeout", 64'(codeWordValid), 64'(1));
      lat = -1;
    end
    cw = codeWordOut;
  endtask

  task automatic accept_cw();
    codeWordAccept = 1'b1;
    @(negedge clk);
    codeWordAccept = 1'b0;
  endtask

  logic [59:0] cw, cwa, cwb, cwab, held;
  logic [63:0] rnd;
  logic [35:0] msg;
  int          lat;

  initial begin
    rst_n          = 1'b0;
    messageIn      = '0;
    encodeMessage  = 1'b0;
    codeWordAccept = 1'b0;

    apow[0] = 4'h1;
    for (int i = 1; i < 15; i++) apow[i] = gf_mul(apow[i-1], 4'h2);
    gpoly[0] = 4'h1;
    for (int k = 1; k <= 6; k++) gpoly[k] = 4'h0;
    for (int r = 1; r <= 6; r++) begin
      for (int k = 6; k >= 1; k--) gpoly[k] = gpoly[k-1] ^ gf_mul(gpoly[k], apow[r]);
      gpoly[0] = gf_mul(gpoly[0], apow[r]);
    end

    fork
      forever begin
        @(negedge clk);
        check("cyc_valid", 64'(codeWordValid), 64'(m_valid));
        check("cyc_busy",  64'(encoderBusy),   64'(m_busy));
        check("cyc_cw",    64'(codeWordOut),   64'(m_cw));
      end
    join_none

    // Pin the model to hand-computed values.
    check("gf_a1xa3",  64'(gf_mul(4'h2, 4'h8)), 64'(4'h3));
    check("gf_a12sq",  64'(gf_mul(4'hF, 4'hF)), 64'(4'hA));
    check("g_poly",    64'({gpoly[6], gpoly[5], gpoly[4], gpoly[3], gpoly[2], gpoly[1], gpoly[0]}),
                       64'(28'h1793CAC));
    check("ref_one",   64'(ref_encode(36'h000000001)), 64'(60'h000000001793CAC));
    check("ref_zero",  64'(ref_encode(36'h0)), 64'(0));

    #1;
    check("rst_busy",  64'(encoderBusy),   64'(0));
    check("rst_valid", 64'(codeWordValid), 64'(0));
    check("rst_cw",    64'(codeWordOut),   64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all-zero message
    run_encode(36'h0, cw, lat);
    check("zero_lat", 64'(lat), 64'(9));
    check("zero_cw",  64'(cw),  64'(0));
    accept_cw();

    // 2: single-symbol message gives g(x) itself
    run_encode(36'h000000001, cw, lat);
    check("one_lat", 64'(lat), 64'(9));
    check("one_cw",  64'(cw),  64'(60'h000000001793CAC));
    accept_cw();

    // 3: random messages
    for (int t = 0; t < 200; t++) begin
      rnd = {$urandom(), $urandom()};
      msg = rnd[35:0];
      run_encode(msg, cw, lat);
      check("rnd_lat", 64'(lat), 64'(9));
      for (int j = 1; j <= 6; j++) check("rnd_synd", 64'(syndrome(cw, j)), 64'(0));
      check("rnd_msg", 64'(cw[59:24]), 64'(msg));
      check("rnd_ref", 64'(cw), 64'(ref_encode(msg)));
      accept_cw();
    end

    // 4: hold in DONE while start requests arrive, then accept+start together
    run_encode(36'h0ABCDEF12, held, lat);
    check("hold_lat", 64'(lat), 64'(9));
    for (int i = 0; i < 20; i++) begin
      messageIn     = 36'h111111111 * 36'(i + 1);
      encodeMessage = i[0];
      @(negedge clk);
      check("hold_cw",    64'(codeWordOut),   64'(held));
      check("hold_valid", 64'(codeWordValid), 64'(1));
    end
    messageIn      = 36'h555555555;
    encodeMessage  = 1'b1;
    codeWordAccept = 1'b1;
    @(negedge clk);
    codeWordAccept = 1'b0;
    encodeMessage  = 1'b0;
    check("acc_busy",  64'(encoderBusy),   64'(0));
    check("acc_valid", 64'(codeWordValid), 64'(0));
    check("acc_cw",    64'(codeWordOut),   64'(held));
    run_encode(36'h555555555, cw, lat);
    check("restart_lat", 64'(lat), 64'(9));
    check("restart_cw",  64'(cw),  64'(ref_encode(36'h555555555)));
    accept_cw();

    // 5: asynchronous reset in the middle of shifting
    messageIn     = 36'hFEDCBA987;
    encodeMessage = 1'b1;
    @(negedge clk);
    encodeMessage = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  64'(encoderBusy),   64'(0));
    check("arst_valid", 64'(codeWordValid), 64'(0));
    check("arst_cw",    64'(codeWordOut),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_encode(36'h000000001, cw, lat);
    check("post_rst_lat", 64'(lat), 64'(9));
    check("post_rst_cw",  64'(cw),  64'(60'h000000001793CAC));
    accept_cw();

    // 6: linearity
    run_encode(36'h123456789, cwa, lat);
    accept_cw();
    run_encode(36'h9ABCDEF01, cwb, lat);
    accept_cw();
    run_encode(36'h123456789 ^ 36'h9ABCDEF01, cwab, lat);
    check("lin_cw", 64'(cwab), 64'(cwa ^ cwb));
    check("lin_ref", 64'(cwa), 64'(ref_encode(36'h123456789)));
    accept_cw();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
